// File: rtl/cache_pkg.sv
// Shared types and field widths for the direct-mapped data cache.
// Address layout: {tag[7:5], index[4:2], offset[1:0]}.
package cache_pkg;

   localparam int NUM_BLOCKS = 8;
   localparam int ADDR_W     = 8;
   localparam int TAG_W      = 3;
   localparam int IDX_W      = 3;
   localparam int OFF_W      = 2;
   localparam int LINE_W     = 32;
   localparam int BLK_AW     = TAG_W + IDX_W;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      FETCH     = 2'd2,
      UPDATE    = 2'd3
   } cache_state_e;

endpackage

// File: rtl/dcache_array.sv
// Line storage for the data cache: valid/dirty/tag/data per line, one
// read port, one byte-store port and one whole-line fill port.
module dcache_array
   import cache_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [IDX_W-1:0]  idx,
   input  logic              byte_we,
   input  logic [OFF_W-1:0]  byte_off,
   input  logic [7:0]        byte_data,
   input  logic              fill_we,
   input  logic [TAG_W-1:0]  fill_tag,
   input  logic [LINE_W-1:0] fill_data,
   output logic              line_valid,
   output logic              line_dirty,
   output logic [TAG_W-1:0]  line_tag,
   output logic [LINE_W-1:0] line_data
);

   logic [NUM_BLOCKS-1:0] valid_q;
   logic [NUM_BLOCKS-1:0] dirty_q;
   logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
   logic [LINE_W-1:0]     data_q [NUM_BLOCKS];

   // A fill always leaves the line clean; a later store hit dirties it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         dirty_q <= '0;
         for (int i = 0; i < NUM_BLOCKS; i++) begin
            tag_q[i]  <= '0;
            data_q[i] <= '0;
         end
      end else if (fill_we) begin
         valid_q[idx] <= 1'b1;
         dirty_q[idx] <= 1'b0;
         tag_q[idx]   <= fill_tag;
         data_q[idx]  <= fill_data;
      end else if (byte_we) begin
         dirty_q[idx] <= 1'b1;
         data_q[idx][{byte_off, 3'b000} +: 8] <= byte_data;
      end
   end

   assign line_valid = valid_q[idx];
   assign line_dirty = dirty_q[idx];
   assign line_tag   = tag_q[idx];
   assign line_data  = data_q[idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Define DCACHE_STATS_EN to add saturating HIT_COUNT / MISS_COUNT outputs.
module dcache_ctrl
   import cache_pkg::*;
(
   input  logic              CLK,
   input  logic              RESET,
   input  logic              READ,
   input  logic              WRITE,
   input  logic [ADDR_W-1:0] ADDRESS,
   input  logic [7:0]        WRITEDATA,
   output logic [7:0]        READDATA,
   output logic              BUSYWAIT,
   output logic              MEM_READ,
   output logic              MEM_WRITE,
   output logic [BLK_AW-1:0] MEM_ADDRESS,
   output logic [LINE_W-1:0] MEM_WRITEDATA,
   input  logic [LINE_W-1:0] MEM_READDATA,
   input  logic              MEM_BUSYWAIT,
   output logic [1:0]        DBG_STATE
`ifdef DCACHE_STATS_EN
   ,
   output logic [15:0]       HIT_COUNT,
   output logic [15:0]       MISS_COUNT
`endif
);

   // Handshakes: READ/WRITE are held by the CPU while BUSYWAIT=1. Our
   // MEM_READ/MEM_WRITE request completes on the first posedge at which
   // MEM_BUSYWAIT is sampled 0 while the request is asserted.

   cache_state_e      state_q, state_d;
   logic [BLK_AW-1:0] miss_addr_q;
   logic [IDX_W-1:0]  arr_idx;
   logic              line_valid, line_dirty;
   logic [TAG_W-1:0]  line_tag;
   logic [LINE_W-1:0] line_data;
   logic              req, hit, busy, byte_we, fill_we, capture;
   logic [7:0]        hit_byte;

   assign req      = READ | WRITE;
   // Outside IDLE the line being serviced is the one latched at the miss.
   assign arr_idx  = (state_q == IDLE) ? ADDRESS[OFF_W +: IDX_W] : miss_addr_q[IDX_W-1:0];
   assign hit      = line_valid && (line_tag == ADDRESS[ADDR_W-1 -: TAG_W]);
   assign hit_byte = line_data[{ADDRESS[OFF_W-1:0], 3'b000} +: 8];

   dcache_array u_array (
      .clk        (CLK),
      .rst_n      (RESET),
      .idx        (arr_idx),
      .byte_we    (byte_we),
      .byte_off   (ADDRESS[OFF_W-1:0]),
      .byte_data  (WRITEDATA),
      .fill_we    (fill_we),
      .fill_tag   (miss_addr_q[BLK_AW-1 -: TAG_W]),
      .fill_data  (MEM_READDATA),
      .line_valid (line_valid),
      .line_dirty (line_dirty),
      .line_tag   (line_tag),
      .line_data  (line_data)
   );

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q     <= IDLE;
         miss_addr_q <= '0;
      end else begin
         state_q <= state_d;
         if (capture) begin
            miss_addr_q <= ADDRESS[ADDR_W-1:OFF_W];
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      busy          = 1'b0;
      byte_we       = 1'b0;
      fill_we       = 1'b0;
      capture       = 1'b0;
      READDATA      = '0;
      MEM_READ      = 1'b0;
      MEM_WRITE     = 1'b0;
      MEM_ADDRESS   = '0;
      MEM_WRITEDATA = '0;
      case (state_q)
         IDLE: begin
            if (req && !hit) begin
               busy    = 1'b1;
               capture = 1'b1;
               state_d = (line_valid && line_dirty) ? WRITEBACK : FETCH;
            end else if (WRITE) begin
               byte_we = 1'b1;
            end else if (READ) begin
               READDATA = hit_byte;
            end
         end
         WRITEBACK: begin
            busy          = 1'b1;
            MEM_WRITE     = 1'b1;
            MEM_ADDRESS   = {line_tag, miss_addr_q[IDX_W-1:0]};
            MEM_WRITEDATA = line_data;
            if (!MEM_BUSYWAIT) begin
               state_d = FETCH;
            end
         end
         FETCH: begin
            busy        = 1'b1;
            MEM_READ    = 1'b1;
            MEM_ADDRESS = miss_addr_q;
            if (!MEM_BUSYWAIT) begin
               fill_we = 1'b1;
               state_d = UPDATE;
            end
         end
         UPDATE: begin
            busy    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // A request held through reset must not stall the CPU.
   assign BUSYWAIT  = busy & RESET;
   assign DBG_STATE = state_q;

`ifdef DCACHE_STATS_EN
   logic        post_fill_q;
   logic [15:0] hit_cnt_q, miss_cnt_q;

   // The IDLE cycle right after UPDATE resolves an already-counted miss.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         post_fill_q <= 1'b0;
         hit_cnt_q   <= '0;
         miss_cnt_q  <= '0;
      end else begin
         post_fill_q <= (state_q == UPDATE);
         if (state_q == IDLE && req && !post_fill_q) begin
            if (hit) begin
               if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
            end else begin
               if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
            end
         end
      end
   end

   assign HIT_COUNT  = hit_cnt_q;
   assign MISS_COUNT = miss_cnt_q;
`endif

endmodule
